// File: rtl/ocp_slave_mem_if.sv
// ocp_if: OCP request/write-data/response bundle between an OCP master and slave.
// Ports (signals):
//   m_* - driven by the master: command, burst fields, write data and response accept
//   s_* - driven by the slave: command/data accept and tagged response beats
// Modports: master (drives m_*), slave (drives s_*).
interface ocp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BLEN_WIDTH = 4,
    parameter int TAGI_WIDTH = 5,
    parameter int INFO_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic [BLEN_WIDTH-1:0]   m_burst_lenght;
    logic [2:0]              m_burst_seq;
    logic [DATA_WIDTH/8-1:0] m_byteen;
    logic [2:0]              m_cmd;
    logic [DATA_WIDTH-1:0]   m_data;
    logic [DATA_WIDTH/8-1:0] m_data_byteen;
    logic                    m_data_last;
    logic [TAGI_WIDTH-1:0]   m_data_tagid;
    logic                    m_data_valid;
    logic [INFO_WIDTH-1:0]   m_req_info;
    logic                    m_resp_accept;
    logic [TAGI_WIDTH-1:0]   m_tagid;
    logic                    s_cmd_accept;
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    s_data_accept;
    logic [1:0]              s_resp;
    logic                    s_resp_last;
    logic [TAGI_WIDTH-1:0]   s_tagid;
    modport master (
        output m_addr, m_burst_lenght, m_burst_seq, m_byteen, m_cmd, m_data, m_data_byteen,
               m_data_last, m_data_tagid, m_data_valid, m_req_info, m_resp_accept, m_tagid,
        input  s_cmd_accept, s_data, s_data_accept, s_resp, s_resp_last, s_tagid
    );
    modport slave (
        input  m_addr, m_burst_lenght, m_burst_seq, m_byteen, m_cmd, m_data, m_data_byteen,
               m_data_last, m_data_tagid, m_data_valid, m_req_info, m_resp_accept, m_tagid,
        output s_cmd_accept, s_data, s_data_accept, s_resp, s_resp_last, s_tagid
    );
endinterface

// File: rtl/ocp_slave_mem.sv
// ocp_slave_mem: OCP slave terminating single-outstanding INCR bursts in a word-addressed register memory.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; abandons any burst in flight
//   bus   - OCP bundle (slave modport); all s_* outputs are registered
module ocp_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BLEN_WIDTH = 4,
    parameter int TAGI_WIDTH = 5,
    parameter int INFO_WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    ocp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [BLEN_WIDTH-1:0] ONE = BLEN_WIDTH'(1);
    localparam logic [2:0] CMD_IDLE = 3'b000, CMD_WR = 3'b001, CMD_RD = 3'b010;
    localparam logic [1:0] RESP_NULL = 2'b00, RESP_DVA = 2'b01, RESP_ERR = 2'b11;
    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RRESP} state_t;
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] addr, addr_n, wr_addr, rd_addr;
    logic [BLEN_WIDTH-1:0] len, len_n, beat, beat_n;
    logic [TAGI_WIDTH-1:0] tag, tag_n;
    logic err, err_n, we, final_beat, resp_n;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic unused_ok;
    assign unused_ok = ^{bus.m_byteen, bus.m_req_info};
    assign wr_addr = addr + ADDR_WIDTH'(beat);
    // Registered outputs are computed from the next-state values, so the
    // read address must also follow the next beat to give latency-1 data.
    assign rd_addr = addr_n + ADDR_WIDTH'(beat_n);
    assign final_beat = beat == len - ONE;
    assign resp_n = state_n == WRESP || state_n == RRESP;
    always_comb begin
        state_n = state;
        addr_n = addr;
        len_n = len;
        beat_n = beat;
        tag_n = tag;
        err_n = err;
        we = 1'b0;
        case (state)
            IDLE: if (bus.s_cmd_accept && bus.m_cmd != CMD_IDLE) begin
                addr_n = bus.m_addr;
                len_n = bus.m_burst_lenght;
                tag_n = bus.m_tagid;
                beat_n = '0;
                err_n = bus.m_burst_seq != 3'b000 || bus.m_burst_lenght == '0;
                if (bus.m_cmd == CMD_WR)
                    state_n = bus.m_burst_lenght == '0 ? WRESP : WDATA;
                else if (bus.m_cmd == CMD_RD)
                    state_n = RRESP;
                else begin
                    err_n = 1'b1;
                    state_n = WRESP;
                end
            end
            WDATA: if (bus.m_data_valid) begin
                // A mismatched tag poisons the response but this beat still lands.
                we = !err;
                beat_n = beat + ONE;
                if (bus.m_data_tagid != tag) err_n = 1'b1;
                if (bus.m_data_last || final_beat) begin
                    state_n = WRESP;
                    if (bus.m_data_last != final_beat) err_n = 1'b1;
                end
            end
            WRESP: if (bus.m_resp_accept) state_n = IDLE;
            RRESP: if (bus.m_resp_accept) begin
                beat_n = beat + ONE;
                if (err || final_beat) state_n = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr <= '0;
            len <= '0;
            beat <= '0;
            tag <= '0;
            err <= 1'b0;
            bus.s_cmd_accept <= 1'b0;
            bus.s_data_accept <= 1'b0;
            bus.s_resp <= RESP_NULL;
            bus.s_resp_last <= 1'b0;
            bus.s_tagid <= '0;
            bus.s_data <= '0;
        end else begin
            state <= state_n;
            addr <= addr_n;
            len <= len_n;
            beat <= beat_n;
            tag <= tag_n;
            err <= err_n;
            bus.s_cmd_accept <= state_n == IDLE;
            bus.s_data_accept <= state_n == WDATA;
            bus.s_resp <= resp_n ? (err_n ? RESP_ERR : RESP_DVA) : RESP_NULL;
            bus.s_resp_last <= state_n == WRESP || (state_n == RRESP && (err_n || beat_n == len_n - ONE));
            bus.s_tagid <= resp_n ? tag_n : '0;
            bus.s_data <= (state_n == RRESP && !err_n) ? mem[rd_addr] : '0;
        end
    end
    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < NBYTES; b++)
                if (bus.m_data_byteen[b]) mem[wr_addr][8*b +: 8] <= bus.m_data[8*b +: 8];
    end
endmodule

// File: tb/tb_ocp_slave_mem.sv
// tb_ocp_slave_mem: directed vector table, corner-case sequences and randomized
// bursts checked against a word-array memory model for ocp_slave_mem.
module tb_ocp_slave_mem;
    localparam logic [2:0] WR = 3'b001, RD = 3'b010;
    localparam logic [1:0] DVA = 2'b01, ERR = 2'b11;
    typedef struct packed {
        logic [2:0]       cmd;
        logic [4:0]       addr;
        logic [3:0]       len;
        logic [2:0]       seq;
        logic [4:0]       tag;
        int               nb;
        int               lastat;
        logic [3:0]       be;
        logic [1:0]       resp;
        logic [3:0][31:0] d;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] wd [16];
    logic [3:0]  wb [16];
    logic [31:0] mem_m [32];
    vec_t vecs [13];
    ocp_if bus ();
    ocp_slave_mem dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, miscompares so far %0d", miscompares);
        $fatal(1);
    end
    function automatic vec_t mk(logic [2:0] c, logic [4:0] a, logic [3:0] l, logic [2:0] s, logic [4:0] t,
                                int nb, int lastat, logic [3:0] be, logic [1:0] r,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic [31:0] d3);
        vec_t v;
        v.cmd = c; v.addr = a; v.len = l; v.seq = s; v.tag = t; v.nb = nb; v.lastat = lastat;
        v.be = be; v.resp = r; v.d = {d3, d2, d1, d0};
        return v;
    endfunction
    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    task automatic send_cmd(input string nm, input logic [2:0] c, input logic [4:0] a, input logic [3:0] l,
                            input logic [2:0] s, input logic [4:0] t);
        int n = 0;
        bus.m_cmd = c; bus.m_addr = a; bus.m_burst_lenght = l; bus.m_burst_seq = s; bus.m_tagid = t;
        bus.m_byteen = 4'hF; bus.m_req_info = 4'($urandom);
        while (!bus.s_cmd_accept && n < 40) begin @(negedge clk); n++; end
        check({nm, " cmd_accept"}, 64'(bus.s_cmd_accept), 64'd1);
        @(negedge clk);
        bus.m_cmd = 3'b000;
        check({nm, " cmd_accept drop"}, 64'(bus.s_cmd_accept), 64'd0);
    endtask
    task automatic wr_beats(input string nm, input logic [4:0] t, input int n, input int lastat, input int bad_at);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s data_accept%0d", nm, i), 64'(bus.s_data_accept), 64'd1);
            bus.m_data_valid = 1'b1; bus.m_data = wd[i]; bus.m_data_byteen = wb[i];
            bus.m_data_tagid = i == bad_at ? ~t : t;
            bus.m_data_last = i == lastat;
            @(negedge clk);
        end
        bus.m_data_valid = 1'b0; bus.m_data_last = 1'b0;
    endtask
    task automatic expect_beat(input string nm, input logic [1:0] r, input logic [4:0] t, input logic l, input logic [31:0] d);
        int n = 0;
        while (bus.s_resp == 2'b00 && n < 40) begin @(negedge clk); n++; end
        check({nm, " resp"}, 64'(bus.s_resp), 64'(r));
        check({nm, " tag"}, 64'(bus.s_tagid), 64'(t));
        check({nm, " last"}, 64'(bus.s_resp_last), 64'(l));
        check({nm, " data"}, 64'(bus.s_data), 64'(d));
        check({nm, " cmd_accept busy"}, 64'(bus.s_cmd_accept), 64'd0);
        bus.m_resp_accept = 1'b1;
        @(negedge clk);
        bus.m_resp_accept = 1'b0;
    endtask
    task automatic idle_check(input string nm);
        check({nm, " idle resp"}, 64'(bus.s_resp), 64'd0);
        check({nm, " idle cmd_accept"}, 64'(bus.s_cmd_accept), 64'd1);
    endtask
    task automatic run_vec(input int idx, input vec_t v);
        string nm = $sformatf("vec%0d", idx);
        send_cmd(nm, v.cmd, v.addr, v.len, v.seq, v.tag);
        if (v.cmd == RD) begin
            check({nm, " rd latency"}, 64'(bus.s_resp != 2'b00), 64'd1);
            for (int i = 0; i < v.nb; i++)
                expect_beat($sformatf("%s rd%0d", nm, i), v.resp, v.tag, i == v.nb - 1, v.d[i]);
        end else begin
            for (int i = 0; i < 4; i++) begin wd[i] = v.d[i]; wb[i] = v.be; end
            if (v.cmd == WR) wr_beats(nm, v.tag, v.nb, v.lastat, -1);
            expect_beat({nm, " wresp"}, v.resp, v.tag, 1'b1, 32'h0);
        end
        idle_check(nm);
    endtask
    task automatic model_write(input logic [4:0] a, input logic [3:0] l, input logic [2:0] s, input int n,
                               input int lastat, input int bad_at, output logic err);
        err = s != 3'b000 || l == 4'd0;
        for (int i = 0; i < n; i++) begin
            if (!err)
                for (int b = 0; b < 4; b++)
                    if (wb[i][b]) mem_m[5'(int'(a) + i)][8*b +: 8] = wd[i][8*b +: 8];
            if (i == bad_at) err = 1'b1;
            if (i == lastat && i < int'(l) - 1) err = 1'b1;
            if (i == int'(l) - 1 && i != lastat) err = 1'b1;
        end
    endtask
    task automatic rand_write(input int k, input logic [4:0] a, input logic [3:0] l, input logic [2:0] s,
                              input int mode, input logic full_be);
        logic [4:0] t = 5'($urandom);
        int n = int'(l);
        int lastat = int'(l) - 1;
        int bad_at = -1;
        logic err;
        string nm = $sformatf("rnd%0d wr", k);
        if (mode == 2 && l >= 4'd2) begin lastat = $urandom_range(0, int'(l) - 2); n = lastat + 1; end
        if (mode == 3) lastat = -1;
        if (n > 0 && $urandom_range(0, 5) == 0) bad_at = $urandom_range(0, n - 1);
        for (int i = 0; i < n; i++) begin wd[i] = $urandom; wb[i] = full_be ? 4'hF : 4'($urandom); end
        model_write(a, l, s, n, lastat, bad_at, err);
        send_cmd(nm, WR, a, l, s, t);
        wr_beats(nm, t, n, lastat, bad_at);
        expect_beat({nm, " wresp"}, err ? ERR : DVA, t, 1'b1, 32'h0);
        idle_check(nm);
    endtask
    task automatic rand_read(input int k, input logic [4:0] a, input logic [3:0] l, input logic [2:0] s);
        logic [4:0] t = 5'($urandom);
        string nm = $sformatf("rnd%0d rd", k);
        send_cmd(nm, RD, a, l, s, t);
        if (s != 3'b000 || l == 4'd0)
            expect_beat({nm, " err"}, ERR, t, 1'b1, 32'h0);
        else
            for (int i = 0; i < int'(l); i++)
                expect_beat($sformatf("%s beat%0d", nm, i), DVA, t, i == int'(l) - 1, mem_m[5'(int'(a) + i)]);
        idle_check(nm);
    endtask
    initial begin
        bus.m_addr = '0; bus.m_burst_lenght = '0; bus.m_burst_seq = '0; bus.m_byteen = '0; bus.m_cmd = '0;
        bus.m_data = '0; bus.m_data_byteen = '0; bus.m_data_last = 1'b0; bus.m_data_tagid = '0;
        bus.m_data_valid = 1'b0; bus.m_req_info = '0; bus.m_resp_accept = 1'b0; bus.m_tagid = '0;
        vecs[0]  = mk(WR, 5'd2,  4'd4, 3'd0, 5'd5,  4, 3, 4'hF, DVA, 32'h11, 32'h22, 32'h33, 32'h44);
        vecs[1]  = mk(RD, 5'd2,  4'd4, 3'd0, 5'd5,  4, 3, 4'hF, DVA, 32'h11, 32'h22, 32'h33, 32'h44);
        vecs[2]  = mk(WR, 5'd31, 4'd3, 3'd0, 5'd1,  3, 2, 4'hF, DVA, 32'hA1, 32'hA2, 32'hA3, 32'h0);
        vecs[3]  = mk(RD, 5'd31, 4'd3, 3'd0, 5'd1,  3, 2, 4'hF, DVA, 32'hA1, 32'hA2, 32'hA3, 32'h0);
        vecs[4]  = mk(WR, 5'd10, 4'd1, 3'd0, 5'd2,  1, 0, 4'hF, DVA, 32'hAABBCCDD, 32'h0, 32'h0, 32'h0);
        vecs[5]  = mk(WR, 5'd10, 4'd1, 3'd0, 5'd2,  1, 0, 4'h5, DVA, 32'h11223344, 32'h0, 32'h0, 32'h0);
        vecs[6]  = mk(RD, 5'd10, 4'd1, 3'd0, 5'd3,  1, 0, 4'hF, DVA, 32'hAA22CC44, 32'h0, 32'h0, 32'h0);
        vecs[7]  = mk(WR, 5'd2,  4'd4, 3'd1, 5'd6,  4, 3, 4'hF, ERR, 32'h99, 32'h98, 32'h97, 32'h96);
        vecs[8]  = mk(RD, 5'd2,  4'd4, 3'd0, 5'd7,  4, 3, 4'hF, DVA, 32'h11, 32'h22, 32'h33, 32'h44);
        vecs[9]  = mk(WR, 5'd20, 4'd4, 3'd0, 5'd8,  2, 1, 4'hF, ERR, 32'h55, 32'h66, 32'h0, 32'h0);
        vecs[10] = mk(RD, 5'd20, 4'd2, 3'd0, 5'd9,  2, 1, 4'hF, DVA, 32'h55, 32'h66, 32'h0, 32'h0);
        vecs[11] = mk(3'b011, 5'd0, 4'd1, 3'd0, 5'd10, 0, 0, 4'hF, ERR, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[12] = mk(RD, 5'd0,  4'd0, 3'd0, 5'd11, 1, 0, 4'hF, ERR, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("reset cmd_accept", 64'(bus.s_cmd_accept), 64'd0);
        check("reset resp", 64'(bus.s_resp), 64'd0);
        check("reset data_accept", 64'(bus.s_data_accept), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset cmd_accept", 64'(bus.s_cmd_accept), 64'd1);
        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);
        // Backpressure: beat 0 must hold while the master stalls.
        send_cmd("bp", RD, 5'd2, 4'd2, 3'd0, 5'd4);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp hold%0d data", k), 64'(bus.s_data), 64'h11);
            check($sformatf("bp hold%0d resp", k), 64'(bus.s_resp), 64'(DVA));
            check($sformatf("bp hold%0d last", k), 64'(bus.s_resp_last), 64'd0);
            check($sformatf("bp hold%0d cmd_accept", k), 64'(bus.s_cmd_accept), 64'd0);
            @(negedge clk);
        end
        expect_beat("bp beat0", DVA, 5'd4, 1'b0, 32'h11);
        expect_beat("bp beat1", DVA, 5'd4, 1'b1, 32'h22);
        idle_check("bp");
        // Reset during beat 1 of a 4-beat read.
        send_cmd("rst", RD, 5'd2, 4'd4, 3'd0, 5'd12);
        expect_beat("rst beat0", DVA, 5'd12, 1'b0, 32'h11);
        check("rst beat1 data", 64'(bus.s_data), 64'h22);
        #2 rst_n = 1'b0;
        #1;
        check("rst async cmd_accept", 64'(bus.s_cmd_accept), 64'd0);
        check("rst async data_accept", 64'(bus.s_data_accept), 64'd0);
        check("rst async resp", 64'(bus.s_resp), 64'd0);
        check("rst async last", 64'(bus.s_resp_last), 64'd0);
        check("rst async tag", 64'(bus.s_tagid), 64'd0);
        check("rst async data", 64'(bus.s_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst release cmd_accept", 64'(bus.s_cmd_accept), 64'd1);
        run_vec(13, mk(RD, 5'd2, 4'd1, 3'd0, 5'd13, 1, 0, 4'hF, DVA, 32'h11, 32'h0, 32'h0, 32'h0));
        // Fill the whole memory so the model knows every word, then randomize.
        for (int k = 0; k < 4; k++) rand_write(k, 5'(8 * k), 4'd8, 3'd0, 0, 1'b1);
        for (int k = 4; k < 70; k++) begin
            int op = $urandom_range(0, 9);
            logic [4:0] a = 5'($urandom);
            logic [3:0] l = $urandom_range(0, 8) == 0 ? 4'd0 : 4'($urandom_range(1, 6));
            logic [2:0] s = $urandom_range(0, 7) == 0 ? 3'($urandom_range(1, 7)) : 3'd0;
            if (op < 5) rand_write(k, a, l, s, $urandom_range(0, 3), 1'b0);
            else if (op < 9) rand_read(k, a, l, s);
            else begin
                string nm = $sformatf("rnd%0d badcmd", k);
                logic [4:0] t = 5'($urandom);
                send_cmd(nm, 3'($urandom_range(3, 7)), a, l, s, t);
                expect_beat(nm, ERR, t, 1'b1, 32'h0);
                idle_check(nm);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ocp_slave_mem.md
Name: ocp_slave_mem

Overview:
- OCP slave endpoint that consumes the team's OCP master-side signal bundle and terminates it in a local word-addressed register memory.
- Accepts single-outstanding INCR burst write and read commands, captures write data beats, and returns tagged DVA/ERR responses.
- Sits directly downstream of the OCP bus interface. Used as the bus target for bring-up and as the reference slave in interconnect benches.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (multiple of 8).
- ADDR_WIDTH, 5, word address width; memory depth = 2**ADDR_WIDTH words.
- BLEN_WIDTH, 4, burst length field width.
- TAGI_WIDTH, 5, tag ID width.
- INFO_WIDTH, 4, request info width (ignored).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m_addr  in  ADDR_WIDTH  burst start word address
- m_burst_lenght  in  BLEN_WIDTH  burst length in beats
- m_burst_seq  in  3  burst sequence; only INCR=3'b000 supported
- m_byteen  in  DATA_WIDTH/8  request byte enables (ignored)
- m_cmd  in  3  IDLE=000, WR=001, RD=010; all other values unsupported
- m_data  in  DATA_WIDTH  write data
- m_data_byteen  in  DATA_WIDTH/8  write byte enables
- m_data_last  in  1  final write beat marker
- m_data_tagid  in  TAGI_WIDTH  write data tag
- m_data_valid  in  1  write data valid
- m_req_info  in  INFO_WIDTH  ignored
- m_resp_accept  in  1  master accepts current response beat
- m_tagid  in  TAGI_WIDTH  command tag
- s_cmd_accept  out  1  command accepted
- s_data  out  DATA_WIDTH  read data
- s_data_accept  out  1  write beat accepted
- s_resp  out  2  NULL=00, DVA=01, ERR=11
- s_resp_last  out  1  final response beat
- s_tagid  out  TAGI_WIDTH  response tag

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 and FSM in IDLE. Memory contents are not reset. Reset mid-burst abandons the burst with no response.
- All outputs are registered. The command handshake is m_cmd!=IDLE && s_cmd_accept. A response beat completes when s_resp!=NULL && m_resp_accept.
- FSM states:
  - IDLE:
    - s_cmd_accept=1 (from the first cycle after reset release).
    - On handshake, latch addr, len, tag, and err = (m_burst_seq!=000) || (len==0).
    - WR with len!=0 -> WDATA. WR with len==0 -> WRESP.
    - RD -> RRESP. Unsupported cmd -> WRESP with err=1.
    - s_cmd_accept drops to 0 the cycle after the handshake.
  - WDATA:
    - s_data_accept=1. Each m_data_valid cycle is one beat.
    - Unless err, write mem[(addr+beat) mod depth], merging only bytes whose m_data_byteen bit is 1.
    - m_data_tagid!=tag sets err; the beat is still written.
    - m_data_last on beat<len-1: terminate the burst, set err, -> WRESP.
    - Beat len-1 without m_data_last: set err, -> WRESP.
    - m_data_valid in any other state is ignored (s_data_accept=0).
  - WRESP:
    - Single beat: s_resp = err?ERR:DVA, s_resp_last=1, s_tagid=tag, s_data=0.
    - Held until m_resp_accept, then -> IDLE. Outputs return to 0 the following cycle.
  - RRESP:
    - First beat is presented the cycle after command accept (latency 1).
    - Beat i: s_data=mem[(addr+i) mod depth], s_resp=DVA, s_tagid=tag, s_resp_last=(i==len-1).
    - Each beat is held stable until m_resp_accept, then advances. After the last beat -> IDLE.
    - If err is set: one ERR beat with s_resp_last=1 and s_data=0.
- Address wrap: beat address is (addr+beat) truncated to ADDR_WIDTH.
- Beat counter: BLEN_WIDTH bits wide.
- Only one burst is outstanding at a time. No command is accepted until the response completes.

Test Plan:
- Write then read, len=4 INCR, addr=2, tag=5, data 0x11..0x44, byteen=F: WRESP DVA, tag=5, last=1. Read returns 0x11,0x22,0x33,0x44 with last only on beat 3, tag=5.
- Wrap-around: write len=3 at addr=31. Read len=3 at addr=31 returns words from addrs 31, 0, 1.
- Partial byte enables: write 0xAABBCCDD with byteen=F, then 0x11223344 with byteen=0101b at the same addr. Read returns 0xAA22CC44.
- Errors:
  - m_burst_seq=3'b001: write data accepted, memory unchanged, response ERR.
  - m_data_last on beat 1 of len=4: ERR after beat 1.
  - m_cmd=3'b011: single ERR beat, last=1.
- Backpressure: read len=2 with m_resp_accept low for 3 cycles. Beat 0 stays stable, s_cmd_accept stays 0, and no beat is skipped.
- Reset mid-read: assert rst_n=0 during beat 1 of 4. All outputs are 0 immediately. After release, s_cmd_accept=1 and a new burst completes normally.
